// File: rtl/vga_fill_engine.sv
// vga_fill_engine: fills a clipped rectangle of the RGB444 framebuffer with one
// colour. Software sets the rectangle through a small register file. The engine
// then writes pixel-pair words on an Avalon-MM master, using the same address
// map and packing that the scanout uses.
//
// state | meaning
// IDLE  | waiting for a start write; registers 0-4 writable
// SETUP | latch clipped bounds and first pixel, present first word
// WRITE | one pixel-pair word on the bus, advance on acceptance
// DONE  | single cycle; sets done/irq on the way back to IDLE
module vga_fill_engine #(
  parameter logic [31:0] VGA_START = 32'h0800_0000,
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned STRIDE    = 1280
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avalon_slave_address,
  input  logic        avalon_slave_read,
  input  logic        avalon_slave_write,
  input  logic [31:0] avalon_slave_writedata,
  output logic [31:0] avalon_slave_readdata,
  output logic        avalon_master_write,
  output logic [31:0] avalon_master_address,
  output logic [31:0] avalon_master_writedata,
  output logic [3:0]  avalon_master_byteenable,
  input  logic        avalon_master_waitrequest,
  output logic        irq
);

  localparam logic [11:0] H_RES_12  = 12'(H_RES);
  localparam logic [11:0] V_RES_12  = 12'(V_RES);
  localparam logic [31:0] STRIDE_32 = 32'(STRIDE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  x0_q, x0_d;
  logic [9:0]  y0_q, y0_d;
  logic [10:0] w_q, w_d;
  logic [10:0] h_q, h_d;
  logic [11:0] color_q, color_d;
  logic [11:0] cur_x_q, cur_x_d;
  logic [11:0] cur_y_q, cur_y_d;
  logic [11:0] x_end_q, x_end_d;
  logic [11:0] y_end_q, y_end_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mst_write_q, mst_write_d;
  logic [31:0] mst_addr_q, mst_addr_d;
  logic [31:0] mst_data_q, mst_data_d;
  logic [3:0]  mst_be_q, mst_be_d;

  logic [11:0] sum_x, sum_y;
  logic [11:0] clip_x, clip_y;
  logic        degenerate;
  logic [11:0] nxt_x, nxt_y;
  logic        cfg_wr, ctrl_wr, start_req, clear_req, accept;
  logic        unused_wdata_hi;

  // Byte address of the word holding pixel (cx, cy).
  function automatic logic [31:0] word_addr(input logic [11:0] cx, input logic [11:0] cy);
    logic [31:0] row_off;
    logic [31:0] col_off;
    row_off = {20'd0, cy} * STRIDE_32;
    col_off = {21'd0, cx[11:1]} << 2;
    return VGA_START + row_off + col_off;
  endfunction

  // Lanes covered when the fill starts at cx with the row ending before xe.
  function automatic logic [3:0] word_be(input logic [11:0] cx, input logic [11:0] xe);
    if (cx[0]) return 4'b1100;
    else if (cx + 12'd1 < xe) return 4'b1111;
    else return 4'b0011;
  endfunction

  // Pixels consumed by the word presented at cx.
  function automatic logic [11:0] word_step(input logic [11:0] cx, input logic [11:0] xe);
    if (!cx[0] && (cx + 12'd1 < xe)) return 12'd2;
    else return 12'd1;
  endfunction

  assign cfg_wr    = avalon_slave_write && (state_q == ST_IDLE);
  assign ctrl_wr   = avalon_slave_write && (avalon_slave_address == 3'd5);
  assign start_req = ctrl_wr && avalon_slave_writedata[0];
  assign clear_req = ctrl_wr && avalon_slave_writedata[1];
  assign accept    = mst_write_q && !avalon_master_waitrequest;

  // Only the low 12 bits of any register carry state.
  assign unused_wdata_hi = ^avalon_slave_writedata[31:12];

  // Clipped rectangle bounds; 12-bit sums cannot overflow from 10+11 bit inputs.
  always_comb begin
    sum_x      = {2'b00, x0_q} + {1'b0, w_q};
    sum_y      = {2'b00, y0_q} + {1'b0, h_q};
    clip_x     = (sum_x > H_RES_12) ? H_RES_12 : sum_x;
    clip_y     = (sum_y > V_RES_12) ? V_RES_12 : sum_y;
    degenerate = (w_q == 11'd0) || (h_q == 11'd0) ||
                 ({2'b00, x0_q} >= H_RES_12) || ({2'b00, y0_q} >= V_RES_12);
  end

  // Register file, read mux and fill sequencing.
  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    w_d         = w_q;
    h_d         = h_q;
    color_d     = color_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    x_end_d     = x_end_q;
    y_end_d     = y_end_q;
    done_d      = done_q;
    rdata_d     = 32'd0;
    mst_write_d = mst_write_q;
    mst_addr_d  = mst_addr_q;
    mst_data_d  = mst_data_q;
    mst_be_d    = mst_be_q;
    nxt_x       = cur_x_q;
    nxt_y       = cur_y_q;

    if (cfg_wr) begin
      case (avalon_slave_address)
        3'd0:    x0_d    = avalon_slave_writedata[9:0];
        3'd1:    y0_d    = avalon_slave_writedata[9:0];
        3'd2:    w_d     = avalon_slave_writedata[10:0];
        3'd3:    h_d     = avalon_slave_writedata[10:0];
        3'd4:    color_d = avalon_slave_writedata[11:0];
        default: ;
      endcase
    end

    if (clear_req) done_d = 1'b0;

    if (avalon_slave_read) begin
      case (avalon_slave_address)
        3'd0:    rdata_d = {22'd0, x0_q};
        3'd1:    rdata_d = {22'd0, y0_q};
        3'd2:    rdata_d = {21'd0, w_q};
        3'd3:    rdata_d = {21'd0, h_q};
        3'd4:    rdata_d = {20'd0, color_q};
        3'd5:    rdata_d = {30'd0, done_q, busy_q};
        default: rdata_d = 32'd0;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d = ST_SETUP;
          done_d  = 1'b0;
        end
      end
      ST_SETUP: begin
        cur_x_d = {2'b00, x0_q};
        cur_y_d = {2'b00, y0_q};
        x_end_d = clip_x;
        y_end_d = clip_y;
        if (degenerate) begin
          state_d = ST_DONE;
        end else begin
          state_d     = ST_WRITE;
          mst_write_d = 1'b1;
          mst_addr_d  = word_addr({2'b00, x0_q}, {2'b00, y0_q});
          mst_be_d    = word_be({2'b00, x0_q}, clip_x);
          mst_data_d  = {4'h0, color_q, 4'h0, color_q};
        end
      end
      ST_WRITE: begin
        if (accept) begin
          nxt_x = cur_x_q + word_step(cur_x_q, x_end_q);
          nxt_y = cur_y_q;
          if (nxt_x >= x_end_q) begin
            nxt_x = {2'b00, x0_q};
            nxt_y = cur_y_q + 12'd1;
          end
          cur_x_d = nxt_x;
          cur_y_d = nxt_y;
          if (nxt_y >= y_end_q) begin
            state_d     = ST_DONE;
            mst_write_d = 1'b0;
            mst_addr_d  = 32'd0;
            mst_data_d  = 32'd0;
            mst_be_d    = 4'd0;
          end else begin
            mst_addr_d = word_addr(nxt_x, nxt_y);
            mst_be_d   = word_be(nxt_x, x_end_q);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // All state registers; reset drops the master write immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      x_end_q     <= '0;
      y_end_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      mst_write_q <= 1'b0;
      mst_addr_q  <= '0;
      mst_data_q  <= '0;
      mst_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      x_end_q     <= x_end_d;
      y_end_q     <= y_end_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mst_write_q <= mst_write_d;
      mst_addr_q  <= mst_addr_d;
      mst_data_q  <= mst_data_d;
      mst_be_q    <= mst_be_d;
    end
  end

  assign avalon_slave_readdata    = rdata_q;
  assign avalon_master_write      = mst_write_q;
  assign avalon_master_address    = mst_addr_q;
  assign avalon_master_writedata  = mst_data_q;
  assign avalon_master_byteenable = mst_be_q;
  assign irq                      = done_q;

endmodule

// File: tb/tb_vga_fill_engine.sv
// Bench for vga_fill_engine: directed plan steps plus random rectangles, with
// writes compared against a per-pixel framebuffer model.
module tb_vga_fill_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  s_addr = 3'd0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_wdata = 32'd0;
  logic [31:0] s_rdata;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_wait = 1'b0;
  logic        irq;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } word_t;

  word_t obs_q[$];
  word_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    rand_wait = 1'b0;
  bit    force_wait = 1'b0;
  int    stall_cycles = 0;
  int    stall_bad = 0;
  word_t mon_w;
  word_t prev_w;
  bit    prev_stall = 1'b0;
  logic [31:0] reg_mask [5] = '{32'h3FF, 32'h3FF, 32'h7FF, 32'h7FF, 32'hFFF};

  always #5 clk = ~clk;

  vga_fill_engine dut (
    .clk                      (clk),
    .reset                    (reset),
    .avalon_slave_address     (s_addr),
    .avalon_slave_read        (s_read),
    .avalon_slave_write       (s_write),
    .avalon_slave_writedata   (s_wdata),
    .avalon_slave_readdata    (s_rdata),
    .avalon_master_write      (m_write),
    .avalon_master_address    (m_addr),
    .avalon_master_writedata  (m_wdata),
    .avalon_master_byteenable (m_be),
    .avalon_master_waitrequest(m_wait),
    .irq                      (irq)
  );

  // Slave stall generator.
  initial forever begin
    @(posedge clk);
    #2;
    m_wait = rand_wait ? ($urandom_range(0, 3) == 0) : force_wait;
  end

  // Bus monitor: records accepted words, checks stability while stalled.
  initial forever begin
    @(negedge clk);
    if (!reset && m_write) begin
      mon_w = '{addr: m_addr, data: m_wdata, be: m_be};
      if (prev_stall && (mon_w != prev_w)) stall_bad++;
      if (m_wait) stall_cycles++;
      else obs_q.push_back(mon_w);
      prev_stall = m_wait;
      prev_w = mon_w;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected writes: every word overlapping the clipped rectangle, lanes set
  // for exactly the pixels inside it.
  task automatic model_fill(input int x0, input int y0, input int w, input int h,
                            input logic [11:0] col);
    int xe;
    int ye;
    word_t e;
    exp_q.delete();
    xe = (x0 + w > 640) ? 640 : x0 + w;
    ye = (y0 + h > 480) ? 480 : y0 + h;
    for (int y = y0; y < ye; y++) begin
      for (int wd = x0 / 2; wd <= (xe - 1) / 2; wd++) begin
        e.be = 4'b0000;
        if (2 * wd >= x0 && 2 * wd < xe) e.be[1:0] = 2'b11;
        if (2 * wd + 1 >= x0 && 2 * wd + 1 < xe) e.be[3:2] = 2'b11;
        e.addr = 32'h0800_0000 + 32'(y * 1280 + wd * 4);
        e.data = {4'h0, col, 4'h0, col};
        if (e.be != 4'b0000) exp_q.push_back(e);
      end
    end
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    s_addr = a;
    s_wdata = d;
    s_write = 1'b1;
    @(posedge clk);
    #1;
    s_write = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk);
    #1;
    s_addr = a;
    s_read = 1'b1;
    @(posedge clk);
    #1;
    s_read = 1'b0;
    d = s_rdata;
  endtask

  task automatic program_rect(input int x0, input int y0, input int w, input int h,
                              input logic [11:0] col);
    reg_write(3'd0, 32'(x0));
    reg_write(3'd1, 32'(y0));
    reg_write(3'd2, 32'(w));
    reg_write(3'd3, 32'(h));
    reg_write(3'd4, {20'd0, col});
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (irq !== 1'b1 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", {31'd0, irq}, 32'd1);
  endtask

  task automatic compare_obs(input string tag);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
      check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
      check({tag, "_be"}, {28'd0, obs_q[i].be}, {28'd0, exp_q[i].be});
    end
  endtask

  task automatic run_fill(input int x0, input int y0, input int w, input int h,
                          input logic [11:0] col, input string tag, output int cyc);
    program_rect(x0, y0, w, h, col);
    model_fill(x0, y0, w, h, col);
    obs_q.delete();
    reg_write(3'd5, 32'd1);
    wait_done(cyc);
    repeat (3) @(negedge clk);
    compare_obs(tag);
  endtask

  initial begin
    logic [31:0] rd;
    int cyc;
    int n;
    int x0, y0, w, h;
    logic [11:0] col;

    // Reset state
    @(negedge clk);
    check("rst_write", {31'd0, m_write}, 32'd0);
    check("rst_addr", m_addr, 32'd0);
    check("rst_data", m_wdata, 32'd0);
    check("rst_be", {28'd0, m_be}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdata", s_rdata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int a = 0; a < 6; a++) begin
      reg_read(3'(a), rd);
      check("rst_reg", rd, 32'd0);
    end

    // Register widths and unmapped addresses
    for (int a = 0; a < 5; a++) reg_write(3'(a), 32'hFFFF_FFFF);
    reg_write(3'd6, 32'hFFFF_FFFF);
    for (int a = 0; a < 5; a++) begin
      reg_read(3'(a), rd);
      check("reg_mask", rd, reg_mask[a]);
    end
    reg_read(3'd6, rd);
    check("reg6_zero", rd, 32'd0);
    reg_read(3'd7, rd);
    check("reg7_zero", rd, 32'd0);

    // Aligned 4x1 fill with cycle-exact timing
    program_rect(0, 0, 4, 1, 12'hABC);
    model_fill(0, 0, 4, 1, 12'hABC);
    obs_q.delete();
    reg_write(3'd5, 32'd1);
    @(negedge clk);
    check("al_setup_write", {31'd0, m_write}, 32'd0);
    @(negedge clk);
    check("al_w0_write", {31'd0, m_write}, 32'd1);
    check("al_w0_addr", m_addr, 32'h0800_0000);
    check("al_w0_data", m_wdata, 32'h0ABC_0ABC);
    check("al_w0_be", {28'd0, m_be}, 32'hF);
    @(negedge clk);
    check("al_w1_write", {31'd0, m_write}, 32'd1);
    check("al_w1_addr", m_addr, 32'h0800_0004);
    @(negedge clk);
    check("al_done_write", {31'd0, m_write}, 32'd0);
    check("al_done_irq_early", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("al_irq", {31'd0, irq}, 32'd1);
    compare_obs("aligned");
    reg_read(3'd5, rd);
    check("al_status", rd, 32'd2);

    // Unaligned 4x1 fill
    run_fill(3, 2, 4, 1, 12'h123, "unaligned", cyc);
    check("un_cycles", 32'(cyc), 32'd6);
    check("un_a0", obs_q[0].addr, 32'h0800_0A04);
    check("un_b0", {28'd0, obs_q[0].be}, 32'hC);
    check("un_a2", obs_q[2].addr, 32'h0800_0A0C);
    check("un_b2", {28'd0, obs_q[2].be}, 32'h3);

    // Clipping at the bottom-right corner
    run_fill(638, 479, 10, 10, 12'hF0F, "clip", cyc);
    check("clip_n", 32'(obs_q.size()), 32'd1);
    check("clip_addr", obs_q[0].addr, 32'h0809_5FFC);
    check("clip_be", {28'd0, obs_q[0].be}, 32'hF);

    // 2x3 fill with a 5-cycle stall on the second word; start while busy
    program_rect(0, 0, 2, 3, 12'h5A3);
    model_fill(0, 0, 2, 3, 12'h5A3);
    obs_q.delete();
    stall_cycles = 0;
    stall_bad = 0;
    reg_write(3'd5, 32'd1);
    n = 0;
    while (obs_q.size() < 1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("stall_first", 32'(obs_q.size()), 32'd1);
    @(posedge clk);
    #1 force_wait = 1'b1;
    reg_write(3'd5, 32'd1);
    reg_read(3'd5, rd);
    check("stall_status_busy", rd, 32'd1);
    @(posedge clk);
    #1 force_wait = 1'b0;
    wait_done(cyc);
    repeat (10) @(negedge clk);
    compare_obs("stall");
    check("stall_cycles", 32'(stall_cycles), 32'd5);
    check("stall_stable", 32'(stall_bad), 32'd0);
    check("stall_a1", obs_q[1].addr, 32'h0800_0500);
    check("stall_a2", obs_q[2].addr, 32'h0800_0A00);
    reg_read(3'd5, rd);
    check("stall_status_done", rd, 32'd2);

    // Degenerate rectangles and done clearing
    run_fill(5, 5, 0, 3, 12'h111, "deg_w0", cyc);
    check("deg_w0_cycles", 32'(cyc), 32'd3);
    run_fill(5, 5, 3, 0, 12'h111, "deg_h0", cyc);
    run_fill(700, 5, 3, 3, 12'h111, "deg_x", cyc);
    run_fill(5, 480, 3, 3, 12'h111, "deg_y", cyc);
    reg_read(3'd5, rd);
    check("deg_status", rd, 32'd2);
    reg_write(3'd5, 32'd2);
    reg_read(3'd5, rd);
    check("clear_status", rd, 32'd0);
    check("clear_irq", {31'd0, irq}, 32'd0);
    run_fill(5, 5, 0, 3, 12'h111, "deg_again", cyc);
    reg_write(3'd5, 32'd3);
    @(negedge clk);
    check("start_clear_irq", {31'd0, irq}, 32'd0);
    wait_done(cyc);
    check("start_clear_cycles", 32'(cyc), 32'd2);

    // Random rectangles, alternating random slave stalls
    for (int i = 0; i < 8; i++) begin
      rand_wait = (i % 2 == 1);
      x0 = $urandom_range(0, 660);
      y0 = $urandom_range(0, 485);
      w = $urandom_range(0, 24);
      h = $urandom_range(0, 5);
      col = 12'($urandom);
      run_fill(x0, y0, w, h, col, "rand", cyc);
      if (!rand_wait) check("rand_cycles", 32'(cyc), 32'(exp_q.size() + 3));
    end
    rand_wait = 1'b0;
    repeat (2) @(posedge clk);

    // Reset in the middle of row 3 of a 640x10 fill, then refill
    program_rect(0, 3, 640, 10, 12'h7C1);
    obs_q.delete();
    reg_write(3'd5, 32'd1);
    reg_write(3'd0, 32'd5);
    reg_read(3'd0, rd);
    check("busy_cfg_ignored", rd, 32'd0);
    n = 0;
    while (obs_q.size() < 645 && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("reached_row3", 32'(obs_q.size() >= 645), 32'd1);
    check("pre_reset_write", {31'd0, m_write}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("reset_write_drop", {31'd0, m_write}, 32'd0);
    check("reset_be", {28'd0, m_be}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    reg_read(3'd5, rd);
    check("reset_status", rd, 32'd0);
    reg_read(3'd2, rd);
    check("reset_w", rd, 32'd0);
    reg_read(3'd4, rd);
    check("reset_color", rd, 32'd0);
    run_fill(0, 3, 640, 10, 12'h7C1, "refill", cyc);
    check("refill_cycles", 32'(cyc), 32'(exp_q.size() + 3));
    reg_read(3'd5, rd);
    check("refill_status", rd, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
